// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared constants and helpers for the digger keyboard front end:
//   - 3-bit direction codes (dmov encoding)
//   - PS/2 prefix bytes (extended, break)
//   - per-player scancode map and lookup
//   - direction priority function (up > down > left > right)
// Held-key masks use bit 0 = up, 1 = down, 2 = left, 3 = right.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package game_pkg;

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Player 0: extended arrow keys
  localparam logic [7:0] P0_UP    = 8'h75;
  localparam logic [7:0] P0_DOWN  = 8'h72;
  localparam logic [7:0] P0_LEFT  = 8'h6B;
  localparam logic [7:0] P0_RIGHT = 8'h74;

  // Player 1: W/S/A/D, non-extended
  localparam logic [7:0] P1_UP    = 8'h1D;
  localparam logic [7:0] P1_DOWN  = 8'h1B;
  localparam logic [7:0] P1_LEFT  = 8'h1C;
  localparam logic [7:0] P1_RIGHT = 8'h23;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  // Highest-priority direction present in a held mask. A one-hot mask
  // maps straight to its own direction, so this doubles as a decoder.
  function automatic logic [2:0] mask_dir(input logic [3:0] m);
    if (m[0])      return DIR_UP;
    else if (m[1]) return DIR_DOWN;
    else if (m[2]) return DIR_LEFT;
    else if (m[3]) return DIR_RIGHT;
    else           return DIR_NONE;
  endfunction

  // One-hot mask bit for a scancode belonging to the given player, or 0.
  function automatic logic [3:0] key_lookup(input int unsigned player,
                                            input logic [7:0] code,
                                            input logic ext);
    logic [3:0] m;
    m = 4'b0000;
    if (player == 0 && ext) begin
      case (code)
        P0_UP:    m = 4'b0001;
        P0_DOWN:  m = 4'b0010;
        P0_LEFT:  m = 4'b0100;
        P0_RIGHT: m = 4'b1000;
        default:  m = 4'b0000;
      endcase
    end else if (player == 1 && !ext) begin
      case (code)
        P1_UP:    m = 4'b0001;
        P1_DOWN:  m = 4'b0010;
        P1_LEFT:  m = 4'b0100;
        P1_RIGHT: m = 4'b1000;
        default:  m = 4'b0000;
      endcase
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_move_ctrl_if.sv
// ---------------------------------------------------------------------------
// ps2_move_ctrl_if
// Bundle between the keyboard front end and the game logic.
//   ps2_clk, ps2_data : raw PS/2 lines into the controller
//   dmov              : 3 bits per player direction
//   mov_stb           : per-player move strobe
//   key_pressed       : any mapped direction key held
//   scan_code/scan_vld: last valid received byte and its update pulse
//   frame_err         : receive error pulse
// master = controller side, slave = game/keyboard side.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ps2_move_ctrl_if #(
  parameter int NUM_PLAYERS = 2
);
  logic                     ps2_clk;
  logic                     ps2_data;
  logic [3*NUM_PLAYERS-1:0] dmov;
  logic [NUM_PLAYERS-1:0]   mov_stb;
  logic                     key_pressed;
  logic [7:0]               scan_code;
  logic                     scan_vld;
  logic                     frame_err;

  modport master (
    input  ps2_clk, ps2_data,
    output dmov, mov_stb, key_pressed, scan_code, scan_vld, frame_err
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  dmov, mov_stb, key_pressed, scan_code, scan_vld, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/ps2_move_ctrl_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx
// PS/2 frame receiver: synchronises the raw lines, detects falling edges
// of the PS/2 clock and assembles start/8 data/odd parity/stop frames.
// A partial frame with no clock edge for TIMEOUT_CYC cycles is abandoned.
//   clk, rst           : system clock, asynchronous active-high reset
//   ps2_clk, ps2_data  : raw asynchronous PS/2 lines
//   scan_code          : last valid byte
//   scan_vld           : one-cycle pulse when scan_code is loaded
//   frame_err          : one-cycle pulse on parity/stop/timeout error
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_rx
  import game_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 20000
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       ps2_clk,
  input  wire logic       ps2_data,
  output logic [7:0]      scan_code,
  output logic            scan_vld,
  output logic            frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_d;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;
  logic                   timeout;

  rx_state_t              state;
  rx_state_t              state_nx;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift;
  logic                   par;
  logic [TW-1:0]          to_cnt;

  // Lines idle high, so the synchroniser resets high to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_d     <= 1'b1;
    end else begin
      clk_sync[0]  <= ps2_clk;
      data_sync[0] <= ps2_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        clk_sync[i]  <= clk_sync[i-1];
        data_sync[i] <= data_sync[i-1];
      end
      clk_d <= clk_s;
    end
  end

  assign clk_s   = clk_sync[SYNC_STAGES-1];
  assign data_s  = data_sync[SYNC_STAGES-1];
  assign fall    = clk_d & ~clk_s;
  assign timeout = (state != RX_IDLE) && (to_cnt == TW'(TIMEOUT_CYC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (timeout) begin
      state_nx = RX_IDLE;
    end else if (fall) begin
      case (state)
        RX_IDLE:   if (!data_s) state_nx = RX_DATA;
        RX_DATA:   if (bit_cnt == 3'd7) state_nx = RX_PARITY;
        RX_PARITY: state_nx = RX_STOP;
        RX_STOP:   state_nx = RX_IDLE;
        default:   state_nx = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      par       <= 1'b0;
      to_cnt    <= '0;
      scan_code <= 8'h00;
      scan_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      scan_vld  <= 1'b0;
      frame_err <= 1'b0;

      if (fall || state == RX_IDLE) to_cnt <= '0;
      else                          to_cnt <= to_cnt + 1'b1;

      if (timeout) begin
        frame_err <= 1'b1;
      end else if (fall) begin
        case (state)
          RX_IDLE: bit_cnt <= 3'd0;
          RX_DATA: begin
            shift   <= {data_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          RX_PARITY: par <= data_s;
          RX_STOP: begin
            if (data_s && (^{shift, par})) begin
              scan_code <= shift;
              scan_vld  <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_move_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_move_ctrl
// Keyboard-to-movement front end: receives PS/2 bytes, tracks E0/F0
// prefixes, keeps a held-key mask and current direction per player and
// issues a move strobe on every direction change plus auto-repeat strobes
// every REPEAT_CYC cycles while a direction is held.
//   sys_clk, rst_key : system clock, asynchronous active-high reset
//   bus (master)     : PS/2 lines in; dmov/mov_stb/key_pressed/
//                      scan_code/scan_vld/frame_err out
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_move_ctrl
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 20000,
  parameter int REPEAT_CYC  = 2500000
) (
  input  wire logic       sys_clk,
  input  wire logic       rst_key,
  ps2_move_ctrl_if.master bus
);

  localparam int RW = $clog2(REPEAT_CYC + 1);

  logic [7:0]               scan_code;
  logic                     scan_vld;
  logic                     frame_err;
  logic                     ext;
  logic                     brk;
  logic                     lookup;
  logic [4*NUM_PLAYERS-1:0] held_all;

  ps2_rx #(
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk       (sys_clk),
    .rst       (rst_key),
    .ps2_clk   (bus.ps2_clk),
    .ps2_data  (bus.ps2_data),
    .scan_code (scan_code),
    .scan_vld  (scan_vld),
    .frame_err (frame_err)
  );

  assign bus.scan_code   = scan_code;
  assign bus.scan_vld    = scan_vld;
  assign bus.frame_err   = frame_err;
  assign bus.key_pressed = |held_all;

  // Prefix bytes only arm flags; any other byte consumes them.
  assign lookup = scan_vld && (scan_code != PS2_EXT) && (scan_code != PS2_BRK);

  always_ff @(posedge sys_clk or posedge rst_key) begin
    if (rst_key) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (scan_vld) begin
      if (scan_code == PS2_EXT) begin
        ext <= 1'b1;
      end else if (scan_code == PS2_BRK) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [3:0]    key;
    logic [3:0]    held;
    logic [3:0]    held_nx;
    logic [2:0]    last;
    logic [2:0]    last_nx;
    logic          evt;
    logic [RW-1:0] rcnt;
    logic          stb;

    always_comb begin
      key     = key_lookup(p, scan_code, ext);
      held_nx = held;
      last_nx = last;
      evt     = 1'b0;
      if (lookup && key != 4'b0000) begin
        if (!brk) begin
          held_nx = held | key;
          // Typematic repeats of the current direction are silent.
          if (mask_dir(key) != last) begin
            last_nx = mask_dir(key);
            evt     = 1'b1;
          end
        end else if ((held & key) != 4'b0000) begin
          held_nx = held & ~key;
          // Releasing the active key falls back to the best still-held one.
          if (mask_dir(key) == last) begin
            last_nx = mask_dir(held_nx);
            evt     = (last_nx != DIR_NONE);
          end
        end
      end
    end

    always_ff @(posedge sys_clk or posedge rst_key) begin
      if (rst_key) begin
        held <= 4'b0000;
        last <= DIR_NONE;
        rcnt <= '0;
        stb  <= 1'b0;
      end else begin
        held <= held_nx;
        last <= last_nx;
        stb  <= 1'b0;
        // A change event takes precedence over expiry: one pulse, one reload.
        if (evt) begin
          rcnt <= RW'(REPEAT_CYC - 1);
          stb  <= 1'b1;
        end else if (last_nx == DIR_NONE) begin
          rcnt <= '0;
        end else if (rcnt == '0) begin
          rcnt <= RW'(REPEAT_CYC - 1);
          stb  <= 1'b1;
        end else begin
          rcnt <= rcnt - 1'b1;
        end
      end
    end

    assign bus.dmov[3*p +: 3]     = last;
    assign bus.mov_stb[p]         = stb;
    assign held_all[4*p +: 4]     = held;
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_move_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ps2_move_ctrl
// Self-checking bench for ps2_move_ctrl. Bytes are pushed to a scoreboard
// queue as frames are sent and popped on each scan_vld; outputs one cycle
// after scan_vld are captured and compared with expected directions.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ps2_move_ctrl;

  localparam int NP   = 2;
  localparam int TO   = 200;
  localparam int REP  = 100;
  localparam int HALF = 20;

  logic sys_clk = 1'b0;
  logic rst_key = 1'b1;

  ps2_move_ctrl_if #(.NUM_PLAYERS(NP)) bus ();

  ps2_move_ctrl #(
    .NUM_PLAYERS (NP),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (TO),
    .REPEAT_CYC  (REP)
  ) dut (
    .sys_clk (sys_clk),
    .rst_key (rst_key),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard and monitor state
  logic [7:0] scan_q[$];
  int         stb0_q[$];
  int         cyc = 0;
  int         err_seen = 0;
  int         post_cnt = 0;
  int         post_cyc = 0;
  logic [5:0] post_dmov = '0;
  logic [1:0] post_stb = '0;
  logic       post_kp = 1'b0;
  bit         pend = 1'b0;

  always @(posedge sys_clk) cyc++;

  always @(negedge sys_clk) begin
    if (rst_key) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        post_dmov = bus.dmov;
        post_stb  = bus.mov_stb;
        post_kp   = bus.key_pressed;
        post_cyc  = cyc;
        post_cnt++;
      end
      pend = bus.scan_vld;
      if (bus.scan_vld) begin
        if (scan_q.size() == 0) check("scan_unexpected", 32'(scan_q.size()), 32'd1);
        else                    check("scan_code", 32'(bus.scan_code), 32'(scan_q.pop_front()));
      end
      if (bus.frame_err) err_seen++;
      if (bus.mov_stb[0]) stb0_q.push_back(cyc);
    end
  end

  task automatic ps2_bit(input logic b);
    bus.ps2_data = b;
    repeat (HALF) @(posedge sys_clk);
    bus.ps2_clk = 1'b0;
    repeat (HALF) @(posedge sys_clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic ps2_frame(input logic [7:0] d, input logic bad_par);
    logic par;
    par = (~^d) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par);
    ps2_bit(1'b1);
    bus.ps2_data = 1'b1;
    repeat (HALF) @(posedge sys_clk);
  endtask

  task automatic send(input logic [7:0] d);
    int c0;
    c0 = post_cnt;
    scan_q.push_back(d);
    ps2_frame(d, 1'b0);
    for (int i = 0; i < 100 && post_cnt == c0; i++) @(posedge sys_clk);
    check("post_seen", 32'(post_cnt - c0), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int c_err;
    int c_post;
    int t0;
    int tb;
    int n_exp;

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst_key      = 1'b1;
    idle(3);
    #1;
    check("rst_dmov",  32'(bus.dmov), 32'd0);
    check("rst_stb",   32'(bus.mov_stb), 32'd0);
    check("rst_kp",    32'(bus.key_pressed), 32'd0);
    check("rst_code",  32'(bus.scan_code), 32'd0);
    check("rst_vld",   32'(bus.scan_vld), 32'd0);
    check("rst_err",   32'(bus.frame_err), 32'd0);
    @(negedge sys_clk);
    rst_key = 1'b0;
    idle(5);

    // P1 up make, then release
    send(8'h1D);
    check("p1_up_dmov", 32'(post_dmov[5:3]), 32'd1);
    check("p1_up_stb",  32'(post_stb[1]), 32'd1);
    check("p1_up_kp",   32'(post_kp), 32'd1);
    check("p1_up_p0",   32'(post_dmov[2:0]), 32'd0);
    send(8'hF0);
    send(8'h1D);
    check("p1_rel_dmov", 32'(post_dmov[5:3]), 32'd0);
    check("p1_rel_kp",   32'(post_kp), 32'd0);
    check("p1_rel_stb",  32'(post_stb), 32'd0);

    // Bad parity: error, no byte, no movement
    c_err  = err_seen;
    c_post = post_cnt;
    ps2_frame(8'h1D, 1'b1);
    idle(20);
    check("par_err",   32'(err_seen - c_err), 32'd1);
    check("par_novld", 32'(post_cnt - c_post), 32'd0);
    check("par_dmov",  32'(bus.dmov), 32'd0);

    // P0: up, left, release left -> back to up
    send(8'hE0); send(8'h75);
    check("p0_up_dmov", 32'(post_dmov[2:0]), 32'd1);
    check("p0_up_stb",  32'(post_stb[0]), 32'd1);
    send(8'hE0); send(8'h6B);
    check("p0_left_dmov", 32'(post_dmov[2:0]), 32'd3);
    check("p0_left_stb",  32'(post_stb[0]), 32'd1);
    check("p0_left_kp",   32'(post_kp), 32'd1);
    send(8'hE0); send(8'hF0); send(8'h6B);
    check("p0_back_dmov", 32'(post_dmov[2:0]), 32'd1);
    check("p0_back_stb",  32'(post_stb[0]), 32'd1);
    check("p0_back_kp",   32'(post_kp), 32'd1);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("p0_none_dmov", 32'(post_dmov[2:0]), 32'd0);
    check("p0_none_kp",   32'(post_kp), 32'd0);

    // Auto-repeat on held right; typematic bytes add nothing
    idle(10);
    stb0_q.delete();
    send(8'hE0); send(8'h74);
    t0 = post_cyc;
    check("rep_dmov", 32'(post_dmov[2:0]), 32'd4);
    idle(250);
    send(8'hE0); send(8'h74);
    idle(200);
    send(8'hE0); send(8'h74);
    idle(130);
    send(8'hE0); send(8'hF0); send(8'h74);
    tb = post_cyc;
    check("rep_rel_dmov", 32'(post_dmov[2:0]), 32'd0);
    check("rep_rel_kp",   32'(post_kp), 32'd0);
    idle(300);
    n_exp = (tb - t0 + REP - 1) / REP;
    check("rep_count", 32'(stb0_q.size()), 32'(n_exp));
    if (stb0_q.size() > 0) check("rep_first", 32'(stb0_q[0]), 32'(t0));
    for (int i = 1; i < stb0_q.size(); i++)
      check("rep_interval", 32'(stb0_q[i] - stb0_q[i-1]), 32'(REP));

    // Timeout on a partial frame, then a clean frame
    c_err = err_seen;
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    bus.ps2_data = 1'b1;
    idle(TO + 50);
    check("to_err", 32'(err_seen - c_err), 32'd1);
    send(8'h1C);
    check("to_next_dmov", 32'(post_dmov[5:3]), 32'd3);
    send(8'hF0); send(8'h1C);
    check("to_rel_dmov", 32'(post_dmov[5:3]), 32'd0);

    // Reset mid-frame while P0 holds up
    send(8'hE0); send(8'h75);
    check("mr_pre_dmov", 32'(post_dmov[2:0]), 32'd1);
    c_err = err_seen;
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    @(posedge sys_clk);
    #2 rst_key = 1'b1;
    #1;
    check("mr_dmov", 32'(bus.dmov), 32'd0);
    check("mr_stb",  32'(bus.mov_stb), 32'd0);
    check("mr_kp",   32'(bus.key_pressed), 32'd0);
    check("mr_code", 32'(bus.scan_code), 32'd0);
    check("mr_err_out", 32'(bus.frame_err), 32'd0);
    bus.ps2_data = 1'b1;
    bus.ps2_clk  = 1'b1;
    idle(5);
    @(negedge sys_clk);
    rst_key = 1'b0;
    idle(TO + 50);
    check("mr_no_err", 32'(err_seen - c_err), 32'd0);
    send(8'h23);
    check("mr_next_p1", 32'(post_dmov[5:3]), 32'd4);
    check("mr_next_p0", 32'(post_dmov[2:0]), 32'd0);
    check("mr_next_stb", 32'(post_stb[1]), 32'd1);
    check("mr_next_kp", 32'(post_kp), 32'd1);

    idle(10);
    check("scan_q_empty", 32'(scan_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
